// File: rtl/online_otf_collector.sv
// online_otf_collector
// Receives radix-2 signed digits MSD-first over a valid/ready handshake and
// converts them on the fly into a two's-complement word without any carry
// propagation. The finished word is presented downstream over a second
// valid/ready handshake.
// Optional feature macro: OTF_ZERO_FLAG_EN adds a registered 'zero' output
// that is high when the presented word is all zeros.
module online_otf_collector #(
    parameter int DIGITS = 8,
    parameter int WIDTH  = DIGITS + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       x,
    input  logic             In_vld,
    output logic             In_rdy,
    output logic [WIDTH-1:0] res,
    output logic             Out_vld,
    input  logic             Out_rdy
`ifdef OTF_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qm;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inRdy;
    logic             r_outVld;
    logic [WIDTH-1:0] r_res;
`ifdef OTF_ZERO_FLAG_EN
    logic             r_zero;
`endif

    logic             w_accept;
    logic             w_digitPos;
    logic             w_digitNeg;
    logic [WIDTH-1:0] w_qNext;
    logic [WIDTH-1:0] w_qmNext;

    // Decode the digit and form the next Q/QM pair by shift-and-append;
    // QM always tracks Q minus one ulp so a -1 digit never needs a borrow.
    always_comb begin
        w_accept   = In_vld & r_inRdy;
        w_digitPos = x[1] & ~x[0];
        w_digitNeg = ~x[1] & x[0];
        w_qNext    = {r_q[WIDTH-2:0], 1'b0};
        w_qmNext   = {r_qm[WIDTH-2:0], 1'b1};
        if (w_digitPos) begin
            w_qNext  = {r_q[WIDTH-2:0], 1'b1};
            w_qmNext = {r_q[WIDTH-2:0], 1'b0};
        end else if (w_digitNeg) begin
            w_qNext  = {r_qm[WIDTH-2:0], 1'b1};
            w_qmNext = {r_qm[WIDTH-2:0], 1'b0};
        end
    end

    // Two-state control: accumulate digits, then hold the finished word
    // until the downstream handshake; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ACCUM;
            r_q      <= '0;
            r_qm     <= '1;
            r_cnt    <= '0;
            r_inRdy  <= 1'b1;
            r_outVld <= 1'b0;
            r_res    <= '0;
`ifdef OTF_ZERO_FLAG_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_CNT) begin
                            r_res    <= w_qNext;
`ifdef OTF_ZERO_FLAG_EN
                            r_zero   <= (w_qNext == '0);
`endif
                            r_outVld <= 1'b1;
                            r_inRdy  <= 1'b0;
                            r_state  <= HOLD;
                            r_q      <= '0;
                            r_qm     <= '1;
                            r_cnt    <= '0;
                        end else begin
                            r_q      <= w_qNext;
                            r_qm     <= w_qmNext;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (Out_rdy) begin
                        r_outVld <= 1'b0;
                        r_inRdy  <= 1'b1;
                        r_state  <= ACCUM;
                    end
                end
                default: begin
                    r_state  <= ACCUM;
                    r_inRdy  <= 1'b1;
                    r_outVld <= 1'b0;
                end
            endcase
        end
    end

    assign In_rdy  = r_inRdy;
    assign Out_vld = r_outVld;
    assign res     = r_res;
`ifdef OTF_ZERO_FLAG_EN
    assign zero    = r_zero;
`endif

endmodule

// File: doc/online_otf_collector.md
# online_otf_collector

Receiving end of the online (digit-serial, MSD-first) arithmetic pipeline. Accepts radix-2 signed digits from an online unit such as an adder or subtractor over a valid/ready handshake. Performs on-the-fly conversion to a two's-complement word as each digit arrives, with no carry propagation. After DIGITS digits it presents the completed word downstream, for example to the Newton iteration controller, through a second valid/ready handshake.

## Interface
Parameters:
- DIGITS, default 8: digits per result word.
- WIDTH, default DIGITS+1: result width in bits. Fixed by DIGITS; not to be overridden.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- x  input  2  signed digit. Value = x[1] - x[0]: 10 = +1, 01 = -1, 00 and 11 = 0.
- In_vld  input  1  upstream digit valid.
- In_rdy  output  1  block ready for a digit. Registered.
- res  output  WIDTH  converted two's-complement integer, sum of d_i·2^(DIGITS-i). Registered.
- Out_vld  output  1  res valid. Registered.
- Out_rdy  input  1  downstream accepts res.
- zero  output  1  present only with OTF_ZERO_FLAG_EN.

## Operation
- Two states:
  - ACCUM: In_rdy=1, Out_vld=0.
  - HOLD: In_rdy=0, Out_vld=1.
- Internal registers:
  - Q, QM: WIDTH bits each. Reset/reload values: Q=0, QM=all ones (QM is Q minus one ulp).
  - cnt: 0..DIGITS-1.
- Digit accept: In_vld & In_rdy at a rising edge. In ACCUM with no accept, all state holds, so gaps on In_vld are allowed.
- Per accepted digit d, shift left by one and append:
  - d=+1: Q←{Q,1}, QM←{Q,0}.
  - d=0: Q←{Q,0}, QM←{QM,1}.
  - d=-1: Q←{QM,1}, QM←{QM,0}.
- Shifts discard the MSB. WIDTH=DIGITS+1 bits always hold the range ±(2^DIGITS - 1), so no overflow occurs.
- Accept when cnt<DIGITS-1: cnt increments.
- Accept when cnt=DIGITS-1:
  - res ← converted value, which is the updated Q computed in the same cycle.
  - Out_vld←1, In_rdy←0, state←HOLD.
  - Q and QM reload; cnt←0.
- HOLD:
  - res and Out_vld stay stable until Out_rdy=1.
  - On Out_vld & Out_rdy: Out_vld←0, In_rdy←1, state←ACCUM.
  - res keeps its last value after the handshake.
- Digits presented while in HOLD are not accepted; upstream holds x and In_vld.
- Reset, asynchronous at any time including mid-word: In_rdy=1, Out_vld=0, res=0, zero=0, Q=0, QM=all ones, cnt=0, state ACCUM. Partial words are discarded.

## Timing
- Throughput: one digit per cycle while In_vld=1.
- Latency: Out_vld rises on the clock edge that accepts the last digit, so it is visible the following cycle.
- A word occupies at least DIGITS+1 cycles: DIGITS accept cycles plus at least one HOLD cycle. In_rdy returns the cycle after the output handshake.
- Simultaneous events in HOLD:
  - Out_rdy=1 with In_vld=1: output handshake completes; the digit is not accepted that cycle and is taken the next cycle.
  - Out_rdy already high on the first HOLD cycle: exactly one cycle of Out_vld.
- No combinational path from input to output: In_rdy, Out_vld and res are all registers.

## Configuration
- Macro: OTF_ZERO_FLAG_EN.
- Defined:
  - Port zero exists.
  - zero is registered alongside res: 1 if the converted word is all zeros, else 0.
  - zero has the same stability rule as res. Reset value 0.
- Undefined: port zero and its logic are absent. All other behaviour is identical.

## Test plan
All cases DIGITS=4, WIDTH=5.
- Digits +1,0,-1,+1 (10,00,01,10) on consecutive cycles, Out_rdy=1 → res=5'b00111 (7); Out_vld high for exactly 1 cycle; In_rdy low 1 cycle, then high.
- Four digits of -1 (01) → res=5'b10001 (-15). Four digits of +1 → res=5'b01111 (15).
- Digits 11,00,11,00 → res=0; zero=1 with OTF_ZERO_FLAG_EN.
- Out_rdy held low for 3 cycles after Out_vld, In_vld held high → res and Out_vld stable; In_rdy=0; no digit consumed. Next word is converted correctly after release.
- In_vld toggled 1,0,0,1,1,0,1 → exactly 4 digits accepted; result matches the gap-free case.
- rst pulsed after 2 accepted digits (asynchronous, mid-cycle) → outputs at reset values immediately. A new 4-digit word then converts from fresh Q/QM.
